sum_seg_scan: RTL and testbench
===============================

# sum_seg_scan

Downstream display stage for the 32-bit CLA sum board. It captures the adder's 32-bit sum and carry-out on a one-cycle load strobe. It then time-multiplexes the eight hex nibbles onto a common-anode, eight-digit seven-segment display, with optional leading-zero blanking. The carry-out is shown on the decimal point of the most significant digit.

## Interface
- CLK_DIV, default 50000: clock cycles per digit slot; legal range 2..2^20.
- DIGITS, default 8: number of display digits; fixed at 8 for this board; other values unsupported.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  one-cycle capture strobe; sum_in and co_in are valid while it is high.
- clear  in  1  synchronous return to the blank (IDLE) display.
- sum_in  in  32  adder sum.
- co_in  in  1  adder carry-out.
- blank_lz  in  1  level; 1 enables leading-zero blanking.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  8  digit enables, active-low, one-hot-low; bit i selects nibble i (bit 0 is the least significant nibble).
- shown  out  1  high while in SCAN.

## Operation
- Two states:
  - IDLE: all outputs blank.
  - SCAN: display active.
- Transitions:
  - IDLE -> SCAN on load.
  - SCAN -> SCAN on load: recapture; the scan position is not disturbed.
  - Any state -> IDLE on clear.
  - clear has priority over load in the same cycle.
- Capture: on a clock edge with load=1 and clear=0, sum_q <= sum_in and co_q <= co_in.
- Counters:
  - A divider counts 0..CLK_DIV-1 and produces a tick on its terminal count.
  - The digit index idx (3 bits) increments on each tick and wraps 7 -> 0.
  - Entering SCAN from IDLE clears both the divider and idx.
- Digit blanking: digit i is blank when blank_lz=1, i != 0, and every nibble at position >= i of sum_q is zero. Digit 0 is never blanked.
- Seg decode: standard hex font 0-F; lower-case b and d for 0xB and 0xD. A blank digit drives seg = 7'h7F with its an bit still low.
- dp is low only when idx = 7 and co_q = 1. This holds even when digit 7 is blanked, so a carry with sum 0 still shows.
- blank_lz is sampled combinationally each cycle, so changing it takes effect on the next output register update.

## Timing
- Reset values: seg = 7'h7F, dp = 1, an = 8'hFF, shown = 0, sum_q = 0, co_q = 0, idx = 0, divider = 0, state = IDLE.
- seg, dp and an are registered; they are driven from idx and sum_q as they stood after the previous edge.
- First visibility: load high at edge N -> capture and state = SCAN at edge N. Then at edge N+1: shown = 1, an = 8'hFE, and seg shows nibble 0 of the captured value.
- Slot length: each digit stays on for exactly CLK_DIV cycles; the full refresh period is 8*CLK_DIV cycles.
- Recapture in SCAN: new data appears on the current digit at the next edge, with no glitch in an.
- clear at edge N: at edge N+1 all outputs are at their reset values and shown = 0. sum_q is retained but not displayed.
- Reset mid-scan: outputs go to reset values immediately, without waiting for a clock edge.
- an never has more than one bit low; in IDLE it is 8'hFF.

## Structure
- Shared package (sum_board_pkg):
  - DIGITS.
  - The hex-to-segment font constants (16 x 7-bit).
  - The state encoding: IDLE = 1'b0, SCAN = 1'b1.
- Sub-module hex7seg: combinational nibble -> active-low segment decode, reusable by other board displays.
- The top level holds the FSM, divider, idx, capture registers, blanking logic and output registers.

## Test plan
All cases use CLK_DIV = 4.
- Reset: hold rst_n low, then release. seg = 7'h7F, an = 8'hFF, dp = 1 and shown = 0 until the first load; load-free cycles keep all outputs blank.
- Full scan: load sum_in = 32'h1234ABCD with co_in = 0 and blank_lz = 0.
  - Required sequence: an = FE/D, FD/C, FB/B, F7/A, EF/4, DF/3, BF/2, 7F/1, each held 4 cycles, then wrap to FE.
  - dp stays 1 throughout.
- Blanking with carry: load sum_in = 32'h0000_00F0 with co_in = 1 and blank_lz = 1.
  - Digits 0 and 1 show 0 and F; digits 2-7 show seg = 7F.
  - Digit 7 has dp = 0.
- Recapture: while digit 3 is on, load 32'hFFFFFFFF. The next edge shows F on digit 3, and idx continues to 4 on schedule.
- Clear priority: assert load and clear in the same cycle. The next edge shows an = FF and shown = 0.
- Async reset: assert rst_n mid-slot. an goes to FF before the next clock edge; after release the block stays in IDLE until a load.

Source files
------------

// File: rtl/sum_board_pkg.sv
// rtl/sum_board_pkg.sv - shared constants, font and state encoding for the sum board displays
package sum_board_pkg;

  localparam int DIGITS = 8;

  // Active-low {g,f,e,d,c,b,a}; entries 0xB and 0xD are the lower-case glyphs.
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/sum_seg_scan_if.sv
// rtl/sum_seg_scan_if.sv - capture inputs and multiplexed display outputs of the sum display
interface sum_seg_scan_if;
  import sum_board_pkg::*;

  logic              load;
  logic              clear;
  logic [31:0]       sum_in;
  logic              co_in;
  logic              blank_lz;
  logic [6:0]        seg;
  logic              dp;
  logic [DIGITS-1:0] an;
  logic              shown;

  modport master (
    output load, clear, sum_in, co_in, blank_lz,
    input  seg, dp, an, shown
  );

  modport slave (
    input  load, clear, sum_in, co_in, blank_lz,
    output seg, dp, an, shown
  );

endinterface

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational nibble to active-low seven-segment decode
module hex7seg
  import sum_board_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_FONT[nibble];

endmodule

// File: rtl/sum_seg_scan.sv
// rtl/sum_seg_scan.sv - captures the adder sum/carry and scans it across eight hex digits
module sum_seg_scan #(
  parameter int CLK_DIV = 50000,
  parameter int DIGITS  = sum_board_pkg::DIGITS
) (
  input  logic           clk,
  input  logic           rst_n,
  sum_seg_scan_if.slave  bus
);
  import sum_board_pkg::*;

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]        IDX_LAST = 3'(DIGITS - 1);

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div;
  logic [2:0]        idx;
  logic [31:0]       sum_q;
  logic              co_q;
  logic              tick;
  logic [3:0]        nibble;
  logic [31:0]       upper;
  logic              digit_blank;
  logic [6:0]        font_seg;
  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] an_q;
  logic              shown_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear)     state_nxt = IDLE;
    else if (bus.load) state_nxt = SCAN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end else if (bus.load && !bus.clear) begin
      sum_q <= bus.sum_in;
      co_q  <= bus.co_in;
    end
  end

  assign tick = (div == DIV_LAST);

  // Counters sit at zero while idle, so entering SCAN always starts on digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
    end else if (state == IDLE || bus.clear) begin
      div <= '0;
      idx <= '0;
    end else if (tick) begin
      div <= '0;
      idx <= idx + 3'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign nibble      = sum_q[{idx, 2'b00} +: 4];
  assign upper       = sum_q >> {idx, 2'b00};
  assign digit_blank = bus.blank_lz && (idx != 3'd0) && (upper == 32'd0);

  hex7seg u_font (
    .nibble (nibble),
    .seg    (font_seg)
  );

  // The carry dot rides on the top digit even when that digit is blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      an_q    <= '1;
      shown_q <= 1'b0;
    end else if (state == SCAN) begin
      seg_q   <= digit_blank ? SEG_BLANK : font_seg;
      dp_q    <= !((idx == IDX_LAST) && co_q);
      an_q    <= ~(DIGITS'(1) << idx);
      shown_q <= 1'b1;
    end else begin
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      an_q    <= '1;
      shown_q <= 1'b0;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.an    = an_q;
  assign bus.shown = shown_q;

endmodule

// File: tb/tb_sum_seg_scan.sv
// tb/tb_sum_seg_scan.sv - self-checking bench for the sum display scanner
module tb_sum_seg_scan;

  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sum_seg_scan_if bus ();

  sum_seg_scan #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference glyphs, active-low {g,f,e,d,c,b,a}.
  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [16:0] BLANK_OUT = {8'hFF, 7'h7F, 1'b1, 1'b0};

  // Expected {an, seg, dp, shown} while digit k of value v is lit.
  function automatic logic [16:0] exp_out(logic [31:0] v, logic co, logic blz, int k);
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    an  = ~(8'd1 << k);
    if (blz && k != 0 && (v >> (4 * k)) == 32'd0) seg = 7'h7F;
    else                                          seg = glyph[v[4*k +: 4]];
    dp  = !(k == 7 && co);
    return {an, seg, dp, 1'b1};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.an, bus.seg, bus.dp, bus.shown};
  endfunction

  task automatic check_idle(string name, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (observed() !== BLANK_OUT) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, observed(), BLANK_OUT);
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  // Loads v from IDLE, then checks n consecutive output cycles. If jl >= 0 a
  // recapture of nv is driven after check jl and takes effect two checks later.
  task automatic run_scan(string name, logic [31:0] v, logic co, logic blz, int n,
                          int jl, logic [31:0] nv, logic nco);
    logic [31:0] cv;
    logic        cc;
    logic [16:0] e;
    bus.load     = 1'b1;
    bus.sum_in   = v;
    bus.co_in    = co;
    bus.blank_lz = blz;
    @(negedge clk);
    bus.load     = 1'b0;
    bus.sum_in   = $urandom;
    bus.co_in    = 1'($urandom_range(0, 1));
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      cv = (jl >= 0 && j >= jl + 2) ? nv : v;
      cc = (jl >= 0 && j >= jl + 2) ? nco : co;
      e  = exp_out(cv, cc, blz, (j / CLK_DIV) % 8);
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, j, observed(), e);
      end
      if (j == jl) begin
        bus.load   = 1'b1;
        bus.sum_in = nv;
        bus.co_in  = nco;
      end
      if (j == jl + 1) bus.load = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.clear    = 1'b0;
    bus.sum_in   = '0;
    bus.co_in    = 1'b0;
    bus.blank_lz = 1'b0;
    check_idle("reset_held", 3);
    rst_n = 1'b1;
    check_idle("reset_released", 10);
  endtask

  task automatic test_full_scan();
    go_idle();
    run_scan("full_scan", 32'h1234ABCD, 1'b0, 1'b0, 8 * CLK_DIV + 8, -1, '0, 1'b0);
  endtask

  task automatic test_blank_carry();
    go_idle();
    run_scan("blank_carry", 32'h000000F0, 1'b1, 1'b1, 8 * CLK_DIV + 4, -1, '0, 1'b0);
    go_idle();
    run_scan("zero_carry", 32'h00000000, 1'b1, 1'b1, 8 * CLK_DIV + 4, -1, '0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int t = 0; t < 6; t++) begin
      v = $urandom >> (4 * $urandom_range(0, 7));
      go_idle();
      run_scan("random", v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8 * CLK_DIV + 4, -1, '0, 1'b0);
    end
  endtask

  task automatic test_recapture();
    go_idle();
    run_scan("recapture", 32'h13572468, 1'b0, 1'b0, 10 * CLK_DIV, 3 * CLK_DIV,
             32'hFFFFFFFF, 1'b1);
  endtask

  task automatic test_clear_priority();
    @(negedge clk);
    bus.load   = 1'b1;
    bus.clear  = 1'b1;
    bus.sum_in = $urandom;
    @(negedge clk);
    bus.load   = 1'b0;
    bus.clear  = 1'b0;
    check_idle("clear_in_scan", 12);
    @(negedge clk);
    bus.load   = 1'b1;
    bus.clear  = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
    bus.clear  = 1'b0;
    check_idle("clear_in_idle", 2 * CLK_DIV);
  endtask

  task automatic test_async_reset();
    go_idle();
    run_scan("pre_reset", 32'h89ABCDEF, 1'b1, 1'b0, 6, -1, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== BLANK_OUT) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", observed(), BLANK_OUT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("after_reset", 2 * CLK_DIV);
    @(negedge clk);
    run_scan("post_reset", 32'h0F0F0F0F, 1'b0, 1'b1, 8 * CLK_DIV, -1, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_blank_carry();
    test_random();
    test_recapture();
    test_clear_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
